multicycle_ctrl: RTL
====================

// Module: multicycle_ctrl
// PURPOSE
//  Control FSM for the multi-cycle MIPS datapath: one shared memory, one ALU.
//  Sequences fetch/decode/execute/memory/writeback for R-type, lw, sw, beq, j, addi.
//  Drives the datapath mux selects and write strobes; stalls on a memory-ready handshake.
//  Keeps a retired-instruction counter.
// PARAMETERS
//  CNT_W  32  width of the retired-instruction counter InstCount
// PORTS
//  Clock        in   1      single clock; all state updates on posedge
//  Reset        in   1      synchronous, active-high
//  Op           in   6      Inst[31:26] from the instruction register
//  Zero         in   1      ALU zero flag
//  MemReady     in   1      shared memory completes the current access this cycle
//  PCWrite      out  1      unconditional PC load
//  PCWriteCond  out  1      PC load if Zero (beq)
//  IorD         out  1      0 = PC addresses memory, 1 = ALUOut addresses memory
//  MemRead      out  1      memory read request
//  MemWrite     out  1      memory write request
//  IRWrite      out  1      instruction register load
//  MemtoReg     out  1      1 = MDR to register write data, 0 = ALUOut
//  RegDst       out  1      1 = rd, 0 = rt
//  RegWrite     out  1      register file write
//  ALUSrcA      out  1      0 = PC, 1 = register A
//  ALUSrcB      out  2      00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
//  ALUOp        out  2      00 = add, 01 = sub, 10 = funct-decoded (into the existing ALU control)
//  PCSource     out  2      00 = ALU result, 01 = ALUOut, 10 = jump target
//  Retire       out  1      one-cycle pulse in the last cycle of each instruction
//  InstCount    out  CNT_W  retired-instruction count
//  State        out  4      current state, debug only
//  Trap         out  1      illegal opcode seen (only with ILLEGAL_TRAP_EN; otherwise tied 0)
// BEHAVIOUR
//  - Reset: at the Reset edge, State <= FETCH (0) and InstCount <= 0.
//    While Reset = 1, every strobe output is forced to 0: PCWrite, PCWriteCond, MemRead, MemWrite,
//    IRWrite, RegWrite, Retire, Trap.
//    Reset mid-instruction abandons the instruction with no partial write.
//  - Outputs are decoded from State. Strobes gated by MemReady are named as such below.
//    Any output not listed for a state is 0.
//  - States and transitions:
//    FETCH(0)
//      Drives MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 00, PCSource = 00.
//      IRWrite = PCWrite = MemReady.
//      MemReady = 0: stay in FETCH. MemReady = 1: go to DECODE.
//    DECODE(1)
//      Drives ALUSrcA = 0, ALUSrcB = 11, ALUOp = 00 (branch target into ALUOut).
//      Next state by Op:
//        100011 or 101011 -> MEMADR
//        000000           -> EXEC
//        000100           -> BRANCH
//        000010           -> JUMP
//        001000           -> ADDIEX
//        any other        -> see CONFIGURATION
//    MEMADR(2)
//      Drives ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00.
//      Op = lw -> MEMRD. Op = sw -> MEMWR.
//    MEMRD(3)
//      Drives MemRead = 1, IorD = 1.
//      Holds until MemReady = 1, then -> MEMWB.
//    MEMWB(4)
//      Drives RegDst = 0, MemtoReg = 1, RegWrite = 1, Retire = 1.
//      -> FETCH.
//    MEMWR(5)
//      Drives MemWrite = 1, IorD = 1.
//      Holds until MemReady = 1. Retire = MemReady. -> FETCH when MemReady = 1.
//    EXEC(6)
//      Drives ALUSrcA = 1, ALUSrcB = 00, ALUOp = 10.
//      -> RWB.
//    RWB(7)
//      Drives RegDst = 1, MemtoReg = 0, RegWrite = 1, Retire = 1.
//      -> FETCH.
//    BRANCH(8)
//      Drives ALUSrcA = 1, ALUSrcB = 00, ALUOp = 01, PCSource = 01, PCWriteCond = 1, Retire = 1.
//      -> FETCH.
//    JUMP(9)
//      Drives PCSource = 10, PCWrite = 1, Retire = 1.
//      -> FETCH.
//    ADDIEX(10)
//      Drives ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00.
//      -> ADDIWB.
//    ADDIWB(11)
//      Drives RegDst = 0, MemtoReg = 0, RegWrite = 1, Retire = 1.
//      -> FETCH.
//    TRAP(12)
//      All strobes are 0.
//    Codes 13-15 are unused: they drive all strobes 0 and go to FETCH next cycle.
//  - Latency with MemReady tied 1: beq and j take 3 cycles; R-type, addi and sw take 4; lw takes 5.
//    Each cycle with MemReady = 0 in FETCH, MEMRD or MEMWR adds exactly 1 cycle.
//  - MemRead and MemWrite are never both 1. MemWrite is asserted only in MEMWR.
//  - InstCount increments by 1 on each edge where Retire = 1.
//    It wraps from 2^CNT_W - 1 to 0 with no flag.
//  - Op is sampled only in DECODE and MEMADR. The IR is stable in those states.
// CONFIGURATION
//  ILLEGAL_TRAP_EN defined:
//    An unknown Op in DECODE goes to TRAP. Trap = 1 while in TRAP.
//    The FSM stays in TRAP until Reset. Retire is not pulsed.
//  ILLEGAL_TRAP_EN undefined:
//    An unknown Op in DECODE goes to FETCH with Retire = 1 (executes as a NOP).
//    TRAP is unreachable. Trap is tied 0.
// TESTING
//  1. Reset held 2 cycles, then released, MemReady = 1:
//     -> State = 0, InstCount = 0, all strobes 0 during reset.
//     -> IRWrite = PCWrite = 1 in the first post-reset cycle.
//  2. Op = 000000, MemReady = 1:
//     -> State sequence 0,1,6,7,0.
//     -> RegWrite = RegDst = 1 only in cycle 4. InstCount +1.
//  3. Op = 100011 with MemReady low for 3 cycles in MEMRD:
//     -> sequence 0,1,2,3,3,3,3,4,0 (8 cycles).
//     -> MemRead = 1 and IorD = 1 throughout MEMRD.
//  4. Op = 000100, once with Zero = 1 and once with Zero = 0:
//     -> 3 cycles each. PCWriteCond = 1 and PCSource = 01 in BRANCH in both cases.
//     -> Retire pulses once per instruction.
//  5. Op = 111111:
//     -> With ILLEGAL_TRAP_EN: State = 12, Trap = 1, held 10+ cycles until Reset.
//     -> Without it: back to FETCH after 2 cycles, InstCount +1.
//  6. CNT_W = 4, 16 back-to-back j instructions:
//     -> InstCount wraps 15 -> 0.
//     -> Reset asserted in MEMWR gives no MemWrite on or after the reset edge.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Control FSM for a multi-cycle MIPS datapath built around one shared
//   memory and one ALU. Sequences fetch/decode/execute/memory/writeback for
//   R-type, lw, sw, beq, j and addi, drives the datapath mux selects and
//   write strobes, stalls on the memory-ready handshake and counts retired
//   instructions.
//
//   Optional feature macro: ILLEGAL_TRAP_EN
//     defined   : an unknown opcode parks the FSM in TRAP (Trap = 1) until Reset
//     undefined : an unknown opcode retires as a NOP; Trap is tied 0
//
// Ports
//   Clock, Reset          single clock, synchronous active-high reset
//   Op[5:0]               opcode field of the instruction register
//   Zero                  ALU zero flag (consumed by the datapath PC enable)
//   MemReady              shared memory completes the current access
//   PCWrite, PCWriteCond  PC load strobes (unconditional / if Zero)
//   IorD                  memory address select (0 = PC, 1 = ALUOut)
//   MemRead, MemWrite     memory request strobes
//   IRWrite               instruction register load
//   MemtoReg, RegDst      register write data / destination selects
//   RegWrite              register file write
//   ALUSrcA, ALUSrcB[1:0] ALU operand selects
//   ALUOp[1:0]            ALU operation class
//   PCSource[1:0]         PC next-value select
//   Retire                pulse in the final cycle of each instruction
//   InstCount[CNT_W-1:0]  retired-instruction count (wraps silently)
//   State[3:0]            current FSM state, debug only
//   Trap                  illegal opcode seen

module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [5:0]       Op,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic             Retire,
  output logic [CNT_W-1:0] InstCount,
  output logic [3:0]       State,
  output logic             Trap
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    RWB    = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    ADDIEX = 4'd10,
    ADDIWB = 4'd11,
    TRAP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_t st;
  logic   op_known;

  // The branch decision (PCWriteCond & Zero) is formed in the datapath PC
  // enable, so the controller itself has no use for Zero.
  logic   zero_unused;
  assign zero_unused = Zero;

  assign op_known = (Op == OP_RTYPE) || (Op == OP_LW) || (Op == OP_SW) ||
                    (Op == OP_BEQ)   || (Op == OP_J)  || (Op == OP_ADDI);

  assign State = st;

  // State register and retired-instruction counter
  always_ff @(posedge Clock) begin
    if (Reset) begin
      st        <= FETCH;
      InstCount <= '0;
    end else begin
      if (Retire) InstCount <= InstCount + CNT_ONE;
      case (st)
        FETCH:  if (MemReady) st <= DECODE;
        DECODE: begin
          case (Op)
            OP_LW, OP_SW: st <= MEMADR;
            OP_RTYPE:     st <= EXEC;
            OP_BEQ:       st <= BRANCH;
            OP_J:         st <= JUMP;
            OP_ADDI:      st <= ADDIEX;
`ifdef ILLEGAL_TRAP_EN
            default:      st <= TRAP;
`else
            default:      st <= FETCH;
`endif
          endcase
        end
        MEMADR: st <= (Op == OP_SW) ? MEMWR : MEMRD;
        MEMRD:  if (MemReady) st <= MEMWB;
        MEMWB:  st <= FETCH;
        MEMWR:  if (MemReady) st <= FETCH;
        EXEC:   st <= RWB;
        RWB:    st <= FETCH;
        BRANCH: st <= FETCH;
        JUMP:   st <= FETCH;
        ADDIEX: st <= ADDIWB;
        ADDIWB: st <= FETCH;
`ifdef ILLEGAL_TRAP_EN
        TRAP:   st <= TRAP;
`else
        TRAP:   st <= FETCH;
`endif
        default: st <= FETCH;
      endcase
    end
  end

  // Output decode from the registered state; Reset overrides every strobe
  // so an abandoned instruction cannot leave a partial write behind.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    Retire      = 1'b0;
    case (st)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = MemReady;
        PCWrite = MemReady;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
`ifndef ILLEGAL_TRAP_EN
        // Unknown opcode retires here as a NOP.
        Retire  = !op_known;
`endif
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        Retire   = 1'b1;
      end
      MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        Retire   = MemReady;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      RWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        Retire   = 1'b1;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCSource    = 2'b01;
        PCWriteCond = 1'b1;
        Retire      = 1'b1;
      end
      JUMP: begin
        PCSource = 2'b10;
        PCWrite  = 1'b1;
        Retire   = 1'b1;
      end
      ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      ADDIWB: begin
        RegWrite = 1'b1;
        Retire   = 1'b1;
      end
      default: ;
    endcase
    if (Reset) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      Retire      = 1'b0;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  assign Trap = (st == TRAP) && !Reset;
`else
  assign Trap = 1'b0;
  logic op_known_unused;
  assign op_known_unused = op_known;
`endif

endmodule
